// File: rtl/adder_unit.sv
// adder_unit: registered WIDTH-bit adder built from 4-bit carry-lookahead groups, with carry/overflow/zero flags
module adder_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] ina,
  input  logic [WIDTH-1:0] inb,
  input  logic             cin,
  output logic [WIDTH-1:0] out,
  output logic             out_valid,
  output logic             cout,
  output logic             ovf,
  output logic             zero
);
  localparam int NG = WIDTH / 4;
  logic [WIDTH-1:0] g, p, c, sum;
  logic [NG-1:0] gg, gp;
  logic [NG:0] gc;
  logic [WIDTH-1:0] out_d, out_q;
  logic cout_d, cout_q, ovf_d, ovf_q, zero_d, zero_q, valid_d, valid_q;
  always_comb begin
    g = ina & inb;
    p = ina ^ inb;
    gg = '0;
    gp = '0;
    gc = '0;
    c = '0;
    for (int k = 0; k < NG; k++) begin
      gp[k] = &p[4*k +: 4];
      gg[k] = g[4*k+3] | (p[4*k+3] & g[4*k+2]) | (&p[4*k+2 +: 2] & g[4*k+1]) | (&p[4*k+1 +: 3] & g[4*k]);
    end
    gc[0] = cin;
    for (int k = 1; k <= NG; k++) gc[k] = gg[k-1] | (gp[k-1] & gc[k-1]);
    for (int k = 0; k < NG; k++) begin
      c[4*k]   = gc[k];
      c[4*k+1] = g[4*k] | (p[4*k] & gc[k]);
      c[4*k+2] = g[4*k+1] | (p[4*k+1] & g[4*k]) | (&p[4*k +: 2] & gc[k]);
      c[4*k+3] = g[4*k+2] | (p[4*k+2] & g[4*k+1]) | (&p[4*k+1 +: 2] & g[4*k]) | (&p[4*k +: 3] & gc[k]);
    end
    sum = p ^ c;
    valid_d = in_valid;
    out_d = in_valid ? sum : out_q;
    cout_d = in_valid ? gc[NG] : cout_q;
    ovf_d = in_valid ? (ina[WIDTH-1] == inb[WIDTH-1]) && (sum[WIDTH-1] != ina[WIDTH-1]) : ovf_q;
    zero_d = in_valid ? (sum == '0) : zero_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      out_q <= '0;
      cout_q <= 1'b0;
      ovf_q <= 1'b0;
      zero_q <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      out_q <= out_d;
      cout_q <= cout_d;
      ovf_q <= ovf_d;
      zero_q <= zero_d;
      valid_q <= valid_d;
    end
  end
  assign out = out_q;
  assign cout = cout_q;
  assign ovf = ovf_q;
  assign zero = zero_q;
  assign out_valid = valid_q;
endmodule

// File: tb/tb_adder_unit.sv
// tb_adder_unit: randomized and directed checks of adder_unit against an arithmetic reference model
module tb_adder_unit;
  logic clk = 1'b0;
  logic rst, in_valid, cin;
  logic [31:0] ina, inb, out;
  logic out_valid, cout, ovf, zero;
  int checks = 0;
  int errors = 0;
  logic [31:0] m_out;
  logic m_cout, m_ovf, m_zero, m_valid;
  always #5 clk = ~clk;
  adder_unit #(.WIDTH(32)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .ina(ina), .inb(inb), .cin(cin),
    .out(out), .out_valid(out_valid), .cout(cout), .ovf(ovf), .zero(zero)
  );
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic cyc(input logic r, input logic v, input logic [31:0] a, input logic [31:0] b, input logic ci, input string tag);
    logic [63:0] s;
    longint ss;
    @(negedge clk);
    rst = r; in_valid = v; ina = a; inb = b; cin = ci;
    if (r) begin
      m_out = '0; m_cout = 0; m_ovf = 0; m_zero = 0; m_valid = 0;
    end else begin
      m_valid = v;
      if (v) begin
        s = {32'b0, a} + {32'b0, b} + {63'b0, ci};
        ss = longint'($signed(a)) + longint'($signed(b)) + longint'(ci);
        m_out = s[31:0];
        m_cout = s[32];
        m_ovf = (ss > 64'sd2147483647) || (ss < -64'sd2147483648);
        m_zero = (m_out == 32'd0);
      end
    end
    @(posedge clk);
    #1;
    chk({tag, "_out"}, out, m_out);
    chk({tag, "_valid"}, out_valid, m_valid);
    chk({tag, "_cout"}, cout, m_cout);
    chk({tag, "_ovf"}, ovf, m_ovf);
    chk({tag, "_zero"}, zero, m_zero);
  endtask
  typedef struct { logic [31:0] a, b; logic ci; logic [31:0] s; logic co, ov, z; } vec_t;
  vec_t dv[12];
  initial begin
    dv[0]  = '{32'd10, 32'd20, 0, 32'd30, 0, 0, 0};
    dv[1]  = '{32'd134, 32'd675, 0, 32'd809, 0, 0, 0};
    dv[2]  = '{32'd12833, 32'd87098, 0, 32'd99931, 0, 0, 0};
    dv[3]  = '{32'd0, 32'd76890, 0, 32'd76890, 0, 0, 0};
    dv[4]  = '{32'd1, 32'd1, 0, 32'd2, 0, 0, 0};
    dv[5]  = '{32'd100000, 32'd700000, 0, 32'd800000, 0, 0, 0};
    dv[6]  = '{32'hFFFFFFFF, 32'h1, 0, 32'h0, 1, 0, 1};
    dv[7]  = '{32'h7FFFFFFF, 32'h1, 0, 32'h80000000, 0, 1, 0};
    dv[8]  = '{32'h80000000, 32'h80000000, 0, 32'h0, 1, 1, 1};
    dv[9]  = '{32'h0000000F, 32'h0, 1, 32'h10, 0, 0, 0};
    dv[10] = '{32'h0FFFFFFF, 32'h0, 1, 32'h10000000, 0, 0, 0};
    dv[11] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 1, 32'hFFFFFFFF, 1, 0, 0};
    rst = 1; in_valid = 1; ina = 32'd5; inb = 32'd7; cin = 0;
    cyc(1, 1, 32'd5, 32'd7, 0, "rst0");
    cyc(1, 1, 32'hFFFFFFFF, 32'h1, 1, "rst1");
    chk("rst_out_const", out, 0);
    for (int i = 0; i < 12; i++) begin
      cyc(0, 1, dv[i].a, dv[i].b, dv[i].ci, $sformatf("dir%0d", i));
      chk($sformatf("dir%0d_sum", i), out, dv[i].s);
      chk($sformatf("dir%0d_flags", i), {cout, ovf, zero, out_valid}, {dv[i].co, dv[i].ov, dv[i].z, 1'b1});
    end
    cyc(0, 1, 32'd1234, 32'd4321, 0, "pre_hold");
    cyc(0, 0, $urandom, $urandom, 1, "hold0");
    chk("hold_const", out, 32'd5555);
    cyc(0, 0, $urandom, $urandom, 0, "hold1");
    cyc(1, 1, 32'd9, 32'd9, 0, "rst_mid");
    chk("rst_mid_const", out, 0);
    for (int i = 0; i < 400; i++) begin
      logic [31:0] a, b;
      int sel;
      sel = $urandom_range(0, 3);
      a = (sel == 0) ? 32'hFFFFFFFF - $urandom_range(0, 3) : $urandom;
      b = (sel == 1) ? 32'h80000000 : (sel == 2) ? -a : $urandom;
      cyc(($urandom_range(0, 29) == 0), ($urandom_range(0, 3) != 0), a, b, $urandom_range(0, 1), "rnd");
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
